// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants, RGB 4:4:4 layout and channel expansion
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    // Replicating the nibble maps 4'h0 -> 8'h00 and 4'hF -> 8'hFF exactly.
    function automatic logic [7:0] expand4(input logic [3:0] c);
        return {c, c};
    endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - N-stage pix_en-gated shift register for hs/vs/blank
module vga_sync_delay #(
    parameter int N = 3,
    parameter int W = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [N*W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr <= {N{RST_VAL}};
        else if (en)
            sr <= {sr[(N-1)*W-1:0], d};
    end

    assign q = sr[N*W-1 -: W];
endmodule

// File: rtl/vga_image_fetch.sv
// rtl/vga_image_fetch.sv - scan position to image-ROM address and registered RGB
// PIXEL_DOUBLE_EN: show each ROM pixel as a 2x2 block.
module vga_image_fetch
    import vga_pkg::*;
#(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int X0 = 240,
    parameter int Y0 = 180,
    parameter int ADDR_W = 15,
    parameter int PIX_W = vga_pkg::PIX_W,
    parameter logic [PIX_W-1:0] BG_COLOR = 12'h000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              pix_en,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_n_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N
);
`ifdef PIXEL_DOUBLE_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam logic [10:0] X_BEG  = 11'(X0);
    localparam logic [10:0] X_END  = 11'(X0 + IMG_W * S);
    localparam logic [10:0] X_LAST = 11'(X0 + IMG_W * S - 1);
    localparam logic [10:0] Y_BEG  = 11'(Y0);
    localparam logic [10:0] Y_END  = 11'(Y0 + IMG_H * S);

    logic [10:0]       xe, ye;
    logic              in_win, line_start, frame_start, line_last;
    logic              col_step, line_step;
    logic [ADDR_W-1:0] col_cnt, row_base, col_cur, row_cur;
    logic              win1, win2, bl1, bl2;
    logic [PIX_W-1:0]  q2, pix_sel;
    logic [2:0]        sync_q;

    always_comb begin
        xe          = {1'b0, x};
        ye          = {1'b0, y};
        in_win      = (xe >= X_BEG) && (xe < X_END) && (ye >= Y_BEG) && (ye < Y_END);
        line_start  = (xe == X_BEG);
        frame_start = line_start && (ye == Y_BEG);
        line_last   = in_win && (xe == X_LAST);
        col_cur     = line_start ? '0 : col_cnt;
        row_cur     = frame_start ? '0 : row_base;
    end

`ifdef PIXEL_DOUBLE_EN
    logic col_ph, line_ph, col_ph_cur, line_ph_cur;

    assign col_ph_cur  = line_start ? 1'b0 : col_ph;
    assign line_ph_cur = frame_start ? 1'b0 : line_ph;
    assign col_step    = col_ph_cur;
    assign line_step   = line_ph_cur;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            col_ph  <= 1'b0;
            line_ph <= 1'b0;
        end else if (pix_en) begin
            col_ph  <= in_win ? ~col_ph_cur : col_ph_cur;
            line_ph <= line_last ? ~line_ph_cur : line_ph_cur;
        end
    end
`else
    assign col_step  = 1'b1;
    assign line_step = 1'b1;
`endif

    // S1: address counters; rom_addr only moves inside the window so it stays in range.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rom_addr <= '0;
            col_cnt  <= '0;
            row_base <= '0;
            win1     <= 1'b0;
            bl1      <= 1'b0;
        end else if (pix_en) begin
            win1     <= in_win;
            bl1      <= blank_n_in;
            col_cnt  <= col_cur;
            row_base <= row_cur;
            if (in_win) begin
                rom_addr <= row_cur + col_cur;
                if (col_step)
                    col_cnt <= col_cur + ADDR_W'(1);
            end
            if (line_last && line_step)
                row_base <= row_cur + ADDR_W'(IMG_W);
        end
    end

    // S2 captures ROM data one tick after the address, S3 registers the colour.
    assign pix_sel = win2 ? q2 : BG_COLOR;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            q2    <= '0;
            win2  <= 1'b0;
            bl2   <= 1'b0;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else if (pix_en) begin
            q2   <= rom_q;
            win2 <= win1;
            bl2  <= bl1;
            if (bl2) begin
                VGA_R <= expand4(pix_sel[R_LSB +: 4]);
                VGA_G <= expand4(pix_sel[G_LSB +: 4]);
                VGA_B <= expand4(pix_sel[B_LSB +: 4]);
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

    vga_sync_delay #(
        .N(3),
        .W(3),
        .RST_VAL(3'b110)
    ) u_sync_delay (
        .clk  (CLOCK_50),
        .rst_n(RESET_N),
        .en   (pix_en),
        .d    ({hs_in, vs_in, blank_n_in}),
        .q    (sync_q)
    );

    assign {VGA_HS, VGA_VS, VGA_BLANK_N} = sync_q;
endmodule

// File: tb/tb_vga_image_fetch.sv
// tb/tb_vga_image_fetch.sv - scoreboard bench for vga_image_fetch
module tb_vga_image_fetch;
    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int X0 = 240;
    localparam int Y0 = 180;
`ifdef PIXEL_DOUBLE_EN
    localparam int S = 2;
    localparam int SCAN_LINES = 4;
`else
    localparam int S = 1;
    localparam int SCAN_LINES = IMG_H;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        hs_in = 1'b1, vs_in = 1'b1, blank_n_in = 1'b0;
    logic [14:0] rom_addr;
    logic [11:0] rom_q = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;
    logic        rom_force = 1'b0;

    vga_image_fetch dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .pix_en     (pix_en),
        .x          (x),
        .y          (y),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .blank_n_in (blank_n_in),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rom_q <= rom_force ? 12'hFFF : rom_addr[11:0];

    int total = 0;
    int bad = 0;
    logic [26:0] sbq[$];
    logic [14:0] last_addr = '0;
    logic [14:0] max_addr = '0;
    localparam logic [26:0] RST_OUT = {24'h0, 3'b110};

    function automatic logic [26:0] outv();
        return {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};
    endfunction

    function automatic bit in_w(int xi, int yi);
        return xi >= X0 && xi < X0 + IMG_W * S && yi >= Y0 && yi < Y0 + IMG_H * S;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int xi, input int yi, input logic hs, input logic vs, input logic bl);
        logic [11:0] q;
        logic [23:0] rgb;
        bit w;
        x = 10'(xi);
        y = 10'(yi);
        hs_in = hs;
        vs_in = vs;
        blank_n_in = bl;
        pix_en = 1'b1;
        @(negedge CLOCK_50);
        pix_en = 1'b0;
        @(negedge CLOCK_50);
        w = in_w(xi, yi);
        if (w) last_addr = 15'(((yi - Y0) / S) * IMG_W + (xi - X0) / S);
        chk("rom_addr", 32'(rom_addr), 32'(last_addr));
        if (rom_addr > max_addr) max_addr = rom_addr;
        q = rom_force ? 12'hFFF : last_addr[11:0];
        rgb = (bl && w) ? {q[11:8], q[11:8], q[7:4], q[7:4], q[3:0], q[3:0]} : 24'h0;
        sbq.push_back({rgb, hs, vs, bl});
        if (sbq.size() == 3) chk("pixel_out", 32'(outv()), 32'(sbq.pop_front()));
    endtask

    initial begin
        int hs_low;
        int hs_first;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_out", 32'(outv()), 32'(RST_OUT));
        chk("reset_addr", 32'(rom_addr), 32'h0);
        RESET_N = 1'b1;

        // Outside the window with blank_n=1 -> background colour.
        repeat (6) tick(100, 100, 1'b1, 1'b1, 1'b1);

        // 96-tick hsync pulse must come out 96 ticks wide, 3 ticks late.
        hs_low = 0;
        hs_first = -1;
        for (int i = 0; i < 110; i++) begin
            tick(i, 10, (i >= 5 && i < 101) ? 1'b0 : 1'b1, 1'b1, 1'b1);
            if (VGA_HS === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
        end
        chk("hs_width", 32'(hs_low), 32'd96);
        chk("hs_delay", 32'(hs_first), 32'd7);

        // Image scan from frame start through the window lines.
        for (int yy = Y0; yy < Y0 + SCAN_LINES; yy++)
            for (int xx = X0 - 2; xx < X0 + IMG_W * S + 2; xx++)
                tick(xx, yy, 1'b1, 1'b1, 1'b1);
        chk("max_addr", 32'(max_addr), 32'(((SCAN_LINES - 1) / S) * IMG_W + IMG_W - 1));

        // blank_n=0 inside the window with an all-ones ROM word.
        rom_force = 1'b1;
        tick(X0, Y0, 1'b1, 1'b1, 1'b0);
        tick(X0 + 1, Y0, 1'b1, 1'b1, 1'b0);
        tick(X0 + 2, Y0, 1'b1, 1'b1, 1'b1);
        tick(X0 + 3, Y0, 1'b1, 1'b1, 1'b1);
        repeat (3) tick(100, 100, 1'b1, 1'b1, 1'b1);
        rom_force = 1'b0;

        // Mid-frame asynchronous reset, then hold with pix_en low.
        tick(50, Y0 + 5, 1'b0, 1'b0, 1'b1);
        tick(51, Y0 + 5, 1'b0, 1'b0, 1'b1);
        #3 RESET_N = 1'b0;
        #1;
        chk("async_reset_out", 32'(outv()), 32'(RST_OUT));
        chk("async_reset_addr", 32'(rom_addr), 32'h0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        x = 10'(X0);
        y = 10'(Y0);
        hs_in = 1'b0;
        vs_in = 1'b0;
        blank_n_in = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        chk("hold_out", 32'(outv()), 32'(RST_OUT));
        chk("hold_addr", 32'(rom_addr), 32'h0);
        sbq.delete();
        last_addr = '0;

        // Resynchronisation from the next frame start.
        for (int i = 0; i < 4; i++) tick(X0 + i, Y0, 1'b1, 1'b1, 1'b1);
        repeat (3) tick(100, 100, 1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
